// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath. Optional build macro: ILLEGAL_TRAP_EN (trap to HALT on bad opcodes).
module multicycle_ctrl #(
    parameter int unsigned MEM_LAT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] LAT = MEM_LAT[2:0];

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_wait;

    logic       pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

    assign last_wait = (cnt_q == LAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        pc_write_c  = 1'b0;
        pc_src      = 2'b00;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_ctrl    = 3'b000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ext_op      = 1'b0;
        reg_write_c = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b01;
                if (last_wait) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
                case (op)
                    OP_LW, OP_SW:    state_d = S_MEMADR;
                    OP_ORI, OP_LUI:  state_d = S_IEXEC;
                    OP_BEQ:          state_d = S_BRANCH;
                    OP_J, OP_JAL:    state_d = S_JUMP;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADDU, FN_SUBU: state_d = S_EXEC;
                            FN_JR:            state_d = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
                            default:          state_d = S_HALT;
`else
                            default:          state_d = S_FETCH;
`endif
                        endcase
                    end
`ifdef ILLEGAL_TRAP_EN
                    default:         state_d = S_HALT;
`else
                    default:         state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                if (last_wait) state_d = S_MEMWB;
                else           cnt_d   = cnt_q + 3'd1;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 2'b01;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                if (last_wait) begin
                    mem_write_c = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = (funct == FN_SUBU) ? 3'b001 : 3'b000;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst     = 2'b01;
                state_d     = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = (op == OP_LUI) ? 3'b011 : 3'b010;
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = 3'b001;
                pc_src     = 2'b01;
                pc_write_c = zero;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c = 1'b1;
                if (op == OP_RTYPE) begin
                    pc_src = 2'b11;
                end else begin
                    pc_src = 2'b10;
                    if (op == OP_JAL) begin
                        reg_write_c = 1'b1;
                        reg_dst     = 2'b10;
                        mem_to_reg  = 2'b10;
                    end
                end
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by the raw reset so nothing can write while it is held low.
    assign pc_write  = pc_write_c  & reset;
    assign ir_write  = ir_write_c  & reset;
    assign mem_read  = mem_read_c  & reset;
    assign mem_write = mem_write_c & reset;
    assign reg_write = reg_write_c & reset;
    assign state     = state_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver pushes per-cycle expected control words
// derived from instruction-level phase lists; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    localparam int unsigned L = 3;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_ctrl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [3:0] state;
        logic       illegal;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pc_write, ir_write, mem_read, mem_write, alu_src_a, ext_op, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl;
    logic [3:0] state;

    int   errors = 0;
    int   checks = 0;
    int   wr_seen = 0;
    int   wr_exp = 0;

    vec_t  sb_v[$];
    string sb_t[$];
    int    seq_st[$];
    bit    seq_last[$];

    multicycle_ctrl #(.MEM_LAT(L)) dut (
        .clk(clk), .reset(rst_n), .op(op), .funct(funct), .zero(zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ext_op(ext_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic string classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: begin
                case (f)
                    6'h21:   return "addu";
                    6'h23:   return "subu";
                    6'h08:   return "jr";
                    default: return "bad";
                endcase
            end
            6'h0d:   return "ori";
            6'h0f:   return "lui";
            6'h23:   return "lw";
            6'h2b:   return "sw";
            6'h04:   return "beq";
            6'h02:   return "j";
            6'h03:   return "jal";
            default: return "bad";
        endcase
    endfunction

    function automatic void add_phase(input int st, input int n);
        for (int i = 0; i < n; i++) begin
            seq_st.push_back(st);
            seq_last.push_back(i == n - 1);
        end
    endfunction

    // Phase list per instruction class; memory phases stretch to L+1 cycles.
    function automatic void build_seq(input string cl);
        seq_st.delete();
        seq_last.delete();
        add_phase(0, L + 1);
        add_phase(1, 1);
        case (cl)
            "lw":          begin add_phase(2, 1); add_phase(3, L + 1); add_phase(4, 1); end
            "sw":          begin add_phase(2, 1); add_phase(5, L + 1); end
            "addu", "subu": begin add_phase(6, 1); add_phase(7, 1); end
            "ori", "lui":  begin add_phase(10, 1); add_phase(11, 1); end
            "beq":         add_phase(8, 1);
            "j", "jal", "jr": add_phase(9, 1);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                add_phase(12, 10);
`endif
            end
        endcase
    endfunction

    function automatic vec_t exp_vec(input int st, input bit last, input string cl, input logic z);
        vec_t v;
        v = '0;
        v.state = st[3:0];
        case (st)
            0: begin
                v.mem_read  = 1'b1;
                v.alu_src_b = 2'b01;
                v.ir_write  = last;
                v.pc_write  = last;
            end
            1: begin v.alu_src_b = 2'b11; v.ext_op = 1'b1; end
            2: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.ext_op = 1'b1; end
            3: v.mem_read = 1'b1;
            4: begin v.reg_write = 1'b1; v.mem_to_reg = 2'b01; end
            5: v.mem_write = last;
            6: begin v.alu_src_a = 1'b1; v.alu_ctrl = (cl == "subu") ? 3'd1 : 3'd0; end
            7: begin v.reg_write = 1'b1; v.reg_dst = 2'b01; end
            8: begin v.alu_src_a = 1'b1; v.alu_ctrl = 3'd1; v.pc_src = 2'b01; v.pc_write = z; end
            9: begin
                v.pc_write = 1'b1;
                v.pc_src   = (cl == "jr") ? 2'b11 : 2'b10;
                if (cl == "jal") begin
                    v.reg_write  = 1'b1;
                    v.reg_dst    = 2'b10;
                    v.mem_to_reg = 2'b10;
                end
            end
            10: begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctrl = (cl == "lui") ? 3'd3 : 3'd2; end
            11: v.reg_write = 1'b1;
            12: v.illegal = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    function automatic vec_t reset_vec();
        vec_t v;
        v = '0;
        v.alu_src_b = 2'b01;
        return v;
    endfunction

    function automatic void push_exp(input vec_t v, input string tag);
        sb_v.push_back(v);
        sb_t.push_back(tag);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        vec_t  act;
        vec_t  e;
        string t;
        if (sb_v.size() > 0) begin
            e = sb_v.pop_front();
            t = sb_t.pop_front();
            act = {pc_write, pc_src, ir_write, mem_read, mem_write, alu_ctrl, alu_src_a,
                   alu_src_b, ext_op, reg_write, reg_dst, mem_to_reg, state, illegal};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s @%0t: got %h expected %h", t, $time, act, e);
            end
            if (act.mem_write === 1'b1) wr_seen++;
        end
    end

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_exp(reset_vec(), "reset");
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // zmode: 0 random zero, 1 force 0, 2 force 1. abort_at: cycle index at which reset drops.
    task automatic run_instr(input logic [5:0] ro, input logic [5:0] rf, input int zmode, input int abort_at);
        string cl;
        int    st;
        cl = classify(ro, rf);
        build_seq(cl);
        for (int k = 0; k < seq_st.size(); k++) begin
            st = seq_st[k];
            if (k == abort_at) begin
                #1;
                rst_n = 1'b0;
                #1;
                check("async_reset_state", 32'(state), 32'd0);
                check("async_reset_strobes",
                      32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
                push_exp(reset_vec(), "reset_mid");
                @(posedge clk);
                #1;
                push_exp(reset_vec(), "reset_mid");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            if (st == 0) begin
                op    = 6'($urandom);
                funct = 6'($urandom);
            end else begin
                op    = ro;
                funct = rf;
            end
            zero = (zmode == 0) ? 1'($urandom) : (zmode == 2);
            push_exp(exp_vec(st, seq_last[k], cl, zero), $sformatf("%s_s%0d_c%0d", cl, st, k));
            @(posedge clk);
            #1;
        end
        if (cl == "sw") wr_exp++;
`ifdef ILLEGAL_TRAP_EN
        if (cl == "bad") reset_cycles(2);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ro, rf;
        int         pick;
        @(posedge clk);
        #1;
        reset_cycles(2);

        run_instr(6'h00, 6'h21, 0, -1);   // addu
        run_instr(6'h23, 6'h00, 0, -1);   // lw
        run_instr(6'h04, 6'h00, 2, -1);   // beq taken
        run_instr(6'h04, 6'h00, 1, -1);   // beq not taken
        run_instr(6'h03, 6'h00, 0, -1);   // jal
        run_instr(6'h00, 6'h08, 0, -1);   // jr
        run_instr(6'h2b, 6'h00, 0, -1);   // sw
        run_instr(6'h2b, 6'h00, 0, L + 4); // sw cut by reset in MEMWR count 1
        run_instr(6'h3f, 6'h00, 0, -1);   // unsupported
        run_instr(6'h00, 6'h00, 0, -1);   // unsupported R-type funct

        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 11);
            rf = 6'($urandom);
            case (pick)
                0: begin ro = 6'h00; rf = 6'h21; end
                1: begin ro = 6'h00; rf = 6'h23; end
                2: begin ro = 6'h00; rf = 6'h08; end
                3: ro = 6'h0d;
                4: ro = 6'h0f;
                5: ro = 6'h23;
                6: ro = 6'h2b;
                7: ro = 6'h04;
                8: ro = 6'h02;
                9: ro = 6'h03;
                default: begin
                    ro = 6'h3f;
                    for (int t = 0; t < 100; t++) begin
                        ro = 6'($urandom);
                        rf = 6'($urandom);
                        if (classify(ro, rf) == "bad") break;
                        ro = 6'h3f;
                    end
                end
            endcase
            run_instr(ro, rf, 0, -1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_v.size()), 32'd0);
        check("mem_write_count", 32'(wr_seen), 32'(wr_exp));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
